// File: rtl/vliw_bundle_fetch.sv
`default_nettype none
// ============================================================================
// Module   : vliw_bundle_fetch
// Brief    : Credit-based bundle fetcher with DEPTH-entry queue, lockstep issue
//            and redirect flush. Optional stats: VLIW_FETCH_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vliw_bundle_fetch #(
    parameter int              NFU      = 2,
    parameter int              DEPTH    = 4,
    parameter int              ADDRW    = 64,
    parameter logic [ADDRW-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [ADDRW-1:0]           imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [NFU*32-1:0]          imem_rdata,
    input  logic                       redirect_valid,
    input  logic [ADDRW-1:0]           redirect_pc,
    output logic                       issue_valid,
    output logic [NFU*32-1:0]          issue_bundle,
    output logic [ADDRW-1:0]           issue_pc,
    input  logic [NFU-1:0]             lane_stall,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef VLIW_FETCH_STATS_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                flush_count
`endif
);

    localparam int              c_PTR_W = $clog2(DEPTH);
    localparam int              c_CNT_W = $clog2(DEPTH+1);
    localparam logic [ADDRW-1:0] c_STEP = ADDRW'(NFU*4);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t               r_state;
    logic [ADDRW-1:0]     r_fetchPc;
    logic [ADDRW-1:0]     r_reqPc;
    logic [NFU*32-1:0]    r_memData [DEPTH];
    logic [ADDRW-1:0]     r_memPc   [DEPTH];
    logic [c_PTR_W-1:0]   r_rdPtr;
    logic [c_PTR_W-1:0]   r_wrPtr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_pop;
    logic                 w_push;
    logic                 w_gnt;
    logic [c_CNT_W-1:0]   w_countAfter;

    assign w_pop        = (r_count != '0) && (lane_stall == '0) && !redirect_valid;
    assign w_push       = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
    assign w_gnt        = (r_state == S_REQ) && imem_gnt;
    assign w_countAfter = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    // Redirect overrides every other event; the in-flight response is dropped when needed
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_fetchPc <= RESET_PC;
            r_reqPc   <= '0;
        end else if (redirect_valid) begin
            r_fetchPc <= redirect_pc;
            case (r_state)
                S_REQ:   r_state <= imem_gnt    ? S_DROP : S_REQ;
                S_WAIT:  r_state <= imem_rvalid ? S_IDLE : S_DROP;
                S_DROP:  r_state <= imem_rvalid ? S_IDLE : S_DROP;
                default: r_state <= S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count < c_DEPTH) r_state <= S_REQ;
                end
                S_REQ: begin
                    if (w_gnt) begin
                        r_state   <= S_WAIT;
                        r_reqPc   <= r_fetchPc;
                        r_fetchPc <= r_fetchPc + c_STEP;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) r_state <= (w_countAfter < c_DEPTH) ? S_REQ : S_IDLE;
                end
                default: begin
                    if (imem_rvalid) r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            r_count <= w_countAfter;
        end
    end

    // Storage needs no reset: outputs are gated by occupancy
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memData[r_wrPtr] <= imem_rdata;
            r_memPc[r_wrPtr]   <= r_reqPc;
        end
    end

    assign imem_req     = (r_state == S_REQ);
    assign imem_addr    = r_fetchPc;
    assign issue_valid  = (r_count != '0);
    assign issue_bundle = issue_valid ? r_memData[r_rdPtr] : '0;
    assign issue_pc     = issue_valid ? r_memPc[r_rdPtr] : '0;
    assign occupancy    = r_count;

`ifdef VLIW_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (issue_valid && (|lane_stall) && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (redirect_valid && (flush_count != 32'hFFFF_FFFF))
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
